// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO, 2**addr_width words, synchronous registered read.
// Ports: clk, rst (async active-low), fifo_in/we write side, re/fifo_out read side,
//        overflow/underflow pulse for one cycle after a rejected write/read.
module fifo_buffer #(
    parameter int data_width = 4,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] fifo_in,
    input  logic                  we,
    input  logic                  re,
    output logic [data_width-1:0] fifo_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int depth = 1 << addr_width;
    localparam logic [addr_width:0]   cnt_full = depth[addr_width:0];
    localparam logic [addr_width:0]   cnt_one  = 1;
    localparam logic [addr_width-1:0] ptr_one  = 1;

    logic [data_width-1:0] mem [depth];
    logic [addr_width-1:0] wp;
    logic [addr_width-1:0] rp;
    logic [addr_width:0]   cnt;

    logic we_v;
    logic re_v;
    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;

    // if-based qualification so an unknown request resolves to "no request"
    always_comb begin
        we_v = 1'b0;
        re_v = 1'b0;
        if (we) we_v = 1'b1;
        if (re) re_v = 1'b1;
    end

    assign full   = (cnt == cnt_full);
    assign empty  = (cnt == '0);
    assign rd_acc = re_v & ~empty;
    // a same-cycle read frees the slot, so a full FIFO still takes the write
    assign wr_acc = we_v & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wp] <= fifo_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            fifo_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wp <= wp + ptr_one;
            if (rd_acc) begin
                fifo_out <= mem[rp];
                rp       <= rp + ptr_one;
            end
            unique case (1'b1)
                wr_acc & ~rd_acc: cnt <= cnt + cnt_one;
                rd_acc & ~wr_acc: cnt <= cnt - cnt_one;
                default: ;
            endcase
            overflow  <= we_v & full & ~rd_acc;
            underflow <= re_v & empty;
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed vector table plus hand-written corner sequences
// for fifo_buffer with default 4-bit data, 16-word depth.
module tb_fifo_buffer;

    logic       clk;
    logic       rst;
    logic [3:0] fifo_in;
    logic       we;
    logic       re;
    logic [3:0] fifo_out;
    logic       overflow;
    logic       underflow;

    int checks;
    int errors;

    fifo_buffer #(.data_width(4), .addr_width(4)) dut (
        .clk(clk),
        .rst(rst),
        .fifo_in(fifo_in),
        .we(we),
        .re(re),
        .fifo_out(fifo_out),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       re;
        logic [3:0] din;
        logic [3:0] out;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [3:0] d);
        we      = w;
        re      = r;
        fifo_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] o,
                              input logic ov, input logic un);
        check({tag, " fifo_out"}, {4'h0, fifo_out}, {4'h0, o});
        check({tag, " overflow"}, {7'h0, overflow}, {7'h0, ov});
        check({tag, " underflow"}, {7'h0, underflow}, {7'h0, un});
    endtask

    initial begin
        logic [3:0] ufl [5];
        checks  = 0;
        errors  = 0;
        we      = 1'b0;
        re      = 1'b0;
        fifo_in = 4'h0;

        ufl[0] = 4'h1; ufl[1] = 4'h4; ufl[2] = 4'ha;
        ufl[3] = 4'h8; ufl[4] = 4'hc;
        for (int i = 0; i < 5; i++)
            vecs[i] = '{we: 1'b0, re: 1'b1, din: ufl[i],
                        out: 4'h0, ov: 1'b0, un: 1'b1};
        for (int i = 5; i < 10; i++)
            vecs[i] = '{we: 1'b1, re: 1'b0, din: 4'hc,
                        out: 4'h0, ov: 1'b0, un: 1'b0};
        for (int i = 10; i < 15; i++)
            vecs[i] = '{we: 1'b0, re: 1'b1, din: 4'h0,
                        out: 4'hc, ov: 1'b0, un: 1'b0};
        vecs[15] = '{we: 1'b0, re: 1'b1, din: 4'h0,
                     out: 4'hc, ov: 1'b0, un: 1'b1};

        // async reset pulse mid-cycle, checked without a clock edge
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        expect_out("reset", 4'h0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        expect_out("post reset", 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].we, vecs[i].re, vecs[i].din);
            expect_out($sformatf("vec%0d", i),
                       vecs[i].out, vecs[i].ov, vecs[i].un);
        end

        // fill to 16, then one rejected write
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'(i));
            expect_out($sformatf("fill%0d", i), 4'hc, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 4'h5);
        expect_out("ovf write", 4'hc, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 4'h0);
            expect_out($sformatf("drain%0d", i), 4'(i), 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 4'h0);
        expect_out("drain empty", 4'hf, 1'b0, 1'b1);

        // second pass across the pointer wrap
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, 4'(i));
        check("wrap fill underflow", {7'h0, underflow}, 8'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 4'h0);
            check($sformatf("wrap rd%0d", i), {4'h0, fifo_out}, {4'h0, 4'(i)});
        end

        // simultaneous read/write while full
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, 4'(i) ^ 4'h3);
        step(1'b1, 1'b1, 4'h7);
        expect_out("full rw", 4'h3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h2);
        check("full rw cnt kept", {7'h0, overflow}, 8'h1);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 4'h0);
            check($sformatf("full rw rd%0d", i), {4'h0, fifo_out},
                  {4'h0, 4'(i) ^ 4'h3});
        end
        step(1'b0, 1'b1, 4'h0);
        expect_out("full rw last", 4'h7, 1'b0, 1'b0);

        // simultaneous read/write while empty
        step(1'b1, 1'b1, 4'h9);
        expect_out("empty rw", 4'h7, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'h0);
        expect_out("empty rw rd", 4'h9, 1'b0, 1'b0);

        // reset with 3 words buffered
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 4'h3);
        we = 1'b0;
        #2 rst = 1'b0;
        #1;
        expect_out("mid reset", 4'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        step(1'b0, 1'b1, 4'h0);
        expect_out("mid reset rd", 4'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
